// File: rtl/pipe_delay_line.sv
// Multi-lane delay line with run-time tap (0..DEPTH), stall, flush and a valid bit per stage.
// Define PIPE_SKEW_EN to add k extra stages on lane k for diagonal systolic-array entry.
module pipe_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int LANES = 4,
   parameter int SELW  = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   en,
   input  logic                   flush,
   input  logic [SELW-1:0]        sel_depth,
   input  logic [LANES-1:0]       in_valid,
   input  logic [LANES*WIDTH-1:0] in_data,
   output logic [LANES-1:0]       out_valid,
   output logic [LANES*WIDTH-1:0] out_data,
   output logic                   busy
);

`ifdef PIPE_SKEW_EN
   localparam int CHAIN = DEPTH + LANES - 1;
`else
   localparam int CHAIN = DEPTH;
`endif
   localparam int TW = $clog2(CHAIN + 1);
   localparam logic [SELW-1:0] DEPTH_SEL = SELW'(DEPTH);

   logic [SELW-1:0]  base_sel;
   logic [LANES-1:0] lane_busy;

   // Out-of-range selects silently clamp to the longest base delay.
   assign base_sel = (sel_depth > DEPTH_SEL) ? DEPTH_SEL : sel_depth;
   assign busy     = |lane_busy;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic             valid_reg [1:CHAIN];
         logic [WIDTH-1:0] data_reg  [1:CHAIN];
         logic [TW-1:0]    tap;
         logic             tap_valid;
         logic [WIDTH-1:0] tap_data;
         logic             any_valid;

`ifdef PIPE_SKEW_EN
         assign tap = TW'(base_sel) + TW'(gi);
`else
         assign tap = TW'(base_sel);
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 1; i <= CHAIN; i++) begin
                  valid_reg[i] <= 1'b0;
                  data_reg[i]  <= '0;
               end
            end else if (flush) begin
               for (int i = 1; i <= CHAIN; i++) begin
                  valid_reg[i] <= 1'b0;
                  data_reg[i]  <= '0;
               end
            end else if (en) begin
               valid_reg[1] <= in_valid[gi];
               data_reg[1]  <= in_data[gi*WIDTH +: WIDTH];
               for (int i = 2; i <= CHAIN; i++) begin
                  valid_reg[i] <= valid_reg[i-1];
                  data_reg[i]  <= data_reg[i-1];
               end
            end
         end

         // Tap 0 is the raw input, so a zero delay bypasses stall and flush.
         always_comb begin
            tap_valid = in_valid[gi];
            tap_data  = in_data[gi*WIDTH +: WIDTH];
            for (int i = 1; i <= CHAIN; i++) begin
               if (tap == TW'(i)) begin
                  tap_valid = valid_reg[i];
                  tap_data  = data_reg[i];
               end
            end
         end

         always_comb begin
            any_valid = 1'b0;
            for (int i = 1; i <= CHAIN; i++) begin
               any_valid = any_valid | valid_reg[i];
            end
         end

         assign out_valid[gi]              = tap_valid;
         assign out_data[gi*WIDTH +: WIDTH] = tap_data;
         assign lane_busy[gi]               = any_valid;
      end
   endgenerate

endmodule

// File: tb/tb_pipe_delay_line.sv
// Directed bench for pipe_delay_line: latency, stall, flush, pass-through, clamp, skew, async reset.
module tb_pipe_delay_line;
   localparam int WIDTH = 8;
   localparam int DEPTH = 4;
   localparam int LANES = 4;
   localparam int SELW  = $clog2(DEPTH + 1);
`ifdef PIPE_SKEW_EN
   localparam int CHAIN = DEPTH + LANES - 1;
`else
   localparam int CHAIN = DEPTH;
`endif

   logic                   clk;
   logic                   rst_n;
   logic                   en;
   logic                   flush;
   logic [SELW-1:0]        sel_depth;
   logic [LANES-1:0]       in_valid;
   logic [LANES*WIDTH-1:0] in_data;
   logic [LANES-1:0]       out_valid;
   logic [LANES*WIDTH-1:0] out_data;
   logic                   busy;

   int errors = 0;
   int checks = 0;
   logic [LANES-1:0]       exp_v;
   logic [LANES*WIDTH-1:0] exp_d;

   // Stall sequence: per-step en, in_valid, in_data and expected outputs.
   logic                   st_en  [0:7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [LANES-1:0]       st_iv  [0:7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0};
   logic [LANES*WIDTH-1:0] st_id  [0:7] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'h77777777, 32'h77777777,
                                            32'h0, 32'h0, 32'h0, 32'h0};
   logic [LANES-1:0]       st_ev  [0:7] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
   logic [LANES*WIDTH-1:0] st_ed  [0:7] = '{32'h0, 32'h0, 32'hA3A2A1A0, 32'hA3A2A1A0, 32'hA3A2A1A0,
                                            32'hB3B2B1B0, 32'h0, 32'h0};

   pipe_delay_line #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .LANES(LANES),
      .SELW(SELW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .flush(flush),
      .sel_depth(sel_depth),
      .in_valid(in_valid),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_data(out_data),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b1;
      en        = 1'b0;
      flush     = 1'b0;
      sel_depth = 3'd3;
      in_valid  = '0;
      in_data   = '0;
      #2 rst_n = 1'b0;
      #1;
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset out_data", 64'(out_data), 64'(0));
      chk("reset busy", 64'(busy), 64'(0));
      step();
      step();
      rst_n = 1'b1;

`ifndef PIPE_SKEW_EN
      // Base latency, sel_depth=3: word n presented in cycle n shows in cycle n+3.
      en = 1'b1;
      for (int c = 0; c <= 7 + CHAIN + 2; c++) begin
         int n;
         in_valid = (c <= 7) ? '1 : '0;
         for (int k = 0; k < LANES; k++)
            in_data[k*WIDTH +: WIDTH] = (c <= 7) ? 8'(16*k + c) : 8'h00;
         #1;
         n = c - 3;
         exp_v = (n >= 0 && n <= 7) ? '1 : '0;
         for (int k = 0; k < LANES; k++)
            exp_d[k*WIDTH +: WIDTH] = (n >= 0 && n <= 7) ? 8'(16*k + n) : 8'h00;
         chk($sformatf("lat c%0d out_valid", c), 64'(out_valid), 64'(exp_v));
         chk($sformatf("lat c%0d out_data", c), 64'(out_data), 64'(exp_d));
         if (c <= 7 || c > 7 + CHAIN)
            chk($sformatf("lat c%0d busy", c), 64'(busy), 64'((c >= 1 && c <= 7) ? 1 : 0));
         step();
      end

      // Stall, sel_depth=2: A and B enter, en drops for two cycles with junk on the inputs.
      sel_depth = 3'd2;
      for (int s = 0; s < 8; s++) begin
         en       = st_en[s];
         in_valid = st_iv[s];
         in_data  = st_id[s];
         #1;
         chk($sformatf("stall s%0d out_valid", s), 64'(out_valid), 64'(st_ev[s]));
         chk($sformatf("stall s%0d out_data", s), 64'(out_data), 64'(st_ed[s]));
         if (s == 3)
            chk("stall busy", 64'(busy), 64'(1));
         step();
      end

      // Flush with en=1 and a new input C that must never emerge.
      sel_depth = 3'd3;
      en        = 1'b1;
      for (int f = 0; f < 3; f++) begin
         in_valid = '1;
         in_data  = {4{8'(8'h40 + 8'(16*f))}};
         step();
      end
      flush    = 1'b1;
      in_valid = '1;
      in_data  = 32'hCCCCCCCC;
      #1;
      chk("flush pre busy", 64'(busy), 64'(1));
      chk("flush pre out_data", 64'(out_data), 64'(32'h40404040));
      step();
      flush    = 1'b0;
      in_valid = '0;
      in_data  = '0;
      #1;
      chk("flush post busy", 64'(busy), 64'(0));
      for (int c = 0; c < 5; c++) begin
         #1;
         chk($sformatf("flush c%0d out_valid", c), 64'(out_valid), 64'(0));
         chk($sformatf("flush c%0d out_data", c), 64'(out_data), 64'(0));
         step();
      end

      // Flush while stalled still clears.
      in_valid = '1;
      in_data  = 32'h11111111;
      step();
      en       = 1'b0;
      flush    = 1'b1;
      in_valid = '0;
      #1;
      chk("flush_stall pre busy", 64'(busy), 64'(1));
      step();
      flush = 1'b0;
      en    = 1'b1;
      #1;
      chk("flush_stall post busy", 64'(busy), 64'(0));

      // Pass-through at sel_depth=0, with en=0 and then during flush.
      sel_depth = 3'd0;
      en        = 1'b0;
      in_valid  = 4'b1010;
      in_data   = 32'h12345678;
      #1;
      chk("pass en0 out_valid", 64'(out_valid), 64'(4'b1010));
      chk("pass en0 out_data", 64'(out_data), 64'(32'h12345678));
      in_valid = 4'b0101;
      in_data  = 32'h9ABCDEF0;
      #1;
      chk("pass en0b out_valid", 64'(out_valid), 64'(4'b0101));
      chk("pass en0b out_data", 64'(out_data), 64'(32'h9ABCDEF0));
      en       = 1'b1;
      flush    = 1'b1;
      in_valid = 4'b1111;
      in_data  = 32'h0F1E2D3C;
      #1;
      chk("pass flush out_valid", 64'(out_valid), 64'(4'b1111));
      chk("pass flush out_data", 64'(out_data), 64'(32'h0F1E2D3C));
      step();

      // Clamp: sel_depth=7 behaves as DEPTH=4.
      flush     = 1'b0;
      sel_depth = 3'd7;
      in_valid  = '1;
      in_data   = 32'hDEADBEEF;
      #1;
      chk("clamp c0 busy", 64'(busy), 64'(0));
      chk("clamp c0 out_valid", 64'(out_valid), 64'(0));
      step();
      in_valid = '0;
      in_data  = '0;
      for (int c = 1; c <= 5; c++) begin
         #1;
         chk($sformatf("clamp c%0d out_valid", c), 64'(out_valid), 64'((c == 4) ? 4'hF : 4'h0));
         chk($sformatf("clamp c%0d out_data", c), 64'(out_data), 64'((c == 4) ? 32'hDEADBEEF : 32'h0));
         step();
      end
`else
      // Skew, sel_depth=1: lane k shows 0xAA exactly 1+k cycles after entry.
      sel_depth = 3'd1;
      en        = 1'b1;
      in_valid  = '1;
      in_data   = 32'hAAAAAAAA;
      #1;
      chk("skew c0 out_valid", 64'(out_valid), 64'(0));
      step();
      in_valid = '0;
      in_data  = '0;
      for (int c = 1; c <= 5; c++) begin
         #1;
         for (int k = 0; k < LANES; k++) begin
            exp_v[k] = (c == 1 + k);
            exp_d[k*WIDTH +: WIDTH] = (c == 1 + k) ? 8'hAA : 8'h00;
         end
         chk($sformatf("skew c%0d out_valid", c), 64'(out_valid), 64'(exp_v));
         chk($sformatf("skew c%0d out_data", c), 64'(out_data), 64'(exp_d));
         step();
      end
`endif

      // Asynchronous reset mid-stream, then a fresh word at sel_depth=2 on lane 0.
      sel_depth = 3'd2;
      en        = 1'b1;
      flush     = 1'b0;
      for (int c = 0; c < 3; c++) begin
         in_valid = '1;
         in_data  = {4{8'(8'h21 + 8'(c))}};
         step();
      end
      #1;
      chk("areset pre out_valid0", 64'(out_valid[0]), 64'(1));
      chk("areset pre busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("areset out_valid", 64'(out_valid), 64'(0));
      chk("areset out_data", 64'(out_data), 64'(0));
      chk("areset busy", 64'(busy), 64'(0));
      in_valid = '1;
      in_data  = 32'h5A5A5A5A;
      rst_n    = 1'b1;
      step();
      in_valid = '0;
      in_data  = '0;
      #1;
      chk("areset c1 out_valid0", 64'(out_valid[0]), 64'(0));
      chk("areset c1 busy", 64'(busy), 64'(1));
      step();
      #1;
      chk("areset c2 out_valid0", 64'(out_valid[0]), 64'(1));
      chk("areset c2 out_data0", 64'(out_data[7:0]), 64'(8'h5A));
      step();
      #1;
      chk("areset c3 out_valid0", 64'(out_valid[0]), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
